uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//   Serial receive end of the SoC UART: the MIPS core's tx is looped to rx at board/bench
//   level, and this block recovers 8N1 frames from the rx pin.
//   Presents each byte to the bridge as a held valid/ack pair.
//   Reports framing and overrun errors as sticky flags the CPU reads and clears.
// PARAMETERS
//   BAUD_DIV  2604  clk cycles per bit (25 MHz / 9600); even, 4..65535
// PORTS
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   rx         in   1  serial line, idle high, asynchronous to clk
//   rx_ack     in   1  CPU/bridge consumed rx_data (1-cycle pulse)
//   err_clr    in   1  clears overrun and frame_err (1-cycle pulse)
//   rx_data    out  8  last good received byte
//   rx_valid   out  1  rx_data holds an unconsumed byte
//   overrun    out  1  sticky: good byte dropped because rx_valid was still set
//   frame_err  out  1  sticky: stop bit sampled low
//   busy       out  1  FSM not in IDLE
// BEHAVIOUR
// - One clock and one asynchronous active-high reset, as fixed above; no other clock.
// - Reset: rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, FSM=IDLE.
//   Both sync flops reset to 1 (idle line).
// - rx passes a 2-flop synchronizer to give rx_s. Decisions use rx_s only.
// - 16-bit down-counter cnt, 3-bit bit index, 8-bit shift register (LSB received first).
// - States:
//   IDLE: busy=0. When rx_s==0 in cycle t0 -> START, cnt=BAUD_DIV/2-1.
//   START: at cnt==0 sample rx_s.
//     1 -> glitch, return to IDLE with no flags.
//     0 -> DATA, cnt=BAUD_DIV-1, idx=0.
//   DATA: at each cnt==0 shift rx_s in at bit idx, then reload cnt.
//     Leave for STOP after idx==7.
//   STOP: at cnt==0 sample rx_s.
//     1 -> commit the byte, go to IDLE.
//     0 -> frame_err<=1, discard the byte, go to WAIT_IDLE.
//   WAIT_IDLE: stay until rx_s==1, then IDLE. A break therefore never re-triggers START.
// - Timing: START sample at t0+BAUD_DIV/2; data bit i sampled at t0+BAUD_DIV/2+(i+1)*BAUD_DIV.
//   Stop bit sampled at t0+BAUD_DIV/2+9*BAUD_DIV; rx_valid rises the following cycle.
//   rx pin to rx_s adds 2 cycles.
// - Commit rules, evaluated in the same cycle:
//   * rx_valid==0, or rx_ack==1: rx_data<=byte, rx_valid<=1, no overrun.
//   * rx_valid==1 and rx_ack==0: keep the old rx_data, overrun<=1, drop the new byte.
// - rx_ack with no commit that cycle: rx_valid<=0. rx_data keeps its value.
//   rx_ack while rx_valid==0 has no effect.
// - err_clr clears overrun and frame_err. If a set and err_clr occur in the same cycle,
//   the set wins.
// - The next frame may start in the cycle after the STOP commit (back-to-back frames OK).
// - Reset asserted mid-frame aborts at once to the reset state. No partial byte is ever visible.
// TESTING (BAUD_DIV=16)
// - Drive 0x55 as 8N1 at 16 clk/bit.
//   -> rx_valid rises 2+8+144+1 cycles after the rx falling edge; rx_data=0x55; flags 0.
// - Send 0xA3 then 0x3C back-to-back, with no ack between them.
//   -> rx_data stays 0xA3, overrun=1.
//   -> Pulse err_clr: overrun=0. rx_ack: rx_valid=0.
// - Send 0x81 with stop bit 0, then hold rx low for 100 cycles.
//   -> frame_err=1, rx_valid=0, busy high until rx returns high.
//   -> No spurious second frame.
// - Drive a 4-cycle low glitch on idle rx.
//   -> FSM returns to IDLE after the START sample; rx_valid=0, frame_err=0.
// - Byte 0x7E pending. Assert rx_ack on the exact cycle 0x12 commits.
//   -> rx_data=0x12, rx_valid=1, overrun=0.
// - Assert reset in the middle of DATA for 0xFF.
//   -> All outputs 0, busy=0. The next 0x42 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronized rx, mid-bit sampling from a half-bit
// start qualification, held valid/ack byte handoff and sticky error flags.
module uart_rx_core #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_ack,
  input  logic       err_clr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  localparam logic [15:0] HALF_BIT = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;
  logic        rx_s;
  logic        commit;

  assign rx_s = sync_q[1];

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sync_d      = {sync_q[0], rx};
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    commit      = 1'b0;

    // Clear first so a set later in this block wins over err_clr.
    if (err_clr) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_BIT;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = FULL_BIT;
            idx_d   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          shreg_d[idx_q] = rx_s;
          cnt_d          = FULL_BIT;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          if (rx_s) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A same-cycle ack frees the holding register, so the new byte lands.
    if (commit) begin
      if (!valid_q || rx_ack) begin
        data_d  = shreg_d;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_ack) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      // NOTE: the shift register is reset too; it is small, and resetting it
      // guarantees no stale partial byte survives an aborted frame.
      shreg_q     <= 8'd0;
      data_q      <= 8'd0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit; outputs are sampled on
// the falling clock edge, away from the active edge.
module tb_uart_rx_core;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  uart_rx_core #(.BAUD_DIV(BIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_ack    (rx_ack),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Caller is at a falling edge; the frame's first edge is driven immediately.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check8("reset_data", rx_data, 8'h00);
    check1("reset_valid", rx_valid, 1'b0);
    check1("reset_busy", busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 0x55: rx_valid rises on the 155th rising edge after the falling edge.
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(posedge clk);
        #1 check1("lat_before", rx_valid, 1'b0);
        @(posedge clk);
        #1 check1("lat_at", rx_valid, 1'b1);
      end
    join
    check8("b55_data", rx_data, 8'h55);
    check1("b55_ovr", overrun, 1'b0);
    check1("b55_ferr", frame_err, 1'b0);
    check1("b55_busy", busy, 1'b0);
    pulse_ack();
    check1("b55_acked", rx_valid, 1'b0);

    // Back-to-back 0xA3, 0x3C without ack: second byte dropped.
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    check8("ovr_data", rx_data, 8'hA3);
    check1("ovr_flag", overrun, 1'b1);
    check1("ovr_valid", rx_valid, 1'b1);
    pulse_clr();
    check1("ovr_cleared", overrun, 1'b0);
    pulse_ack();
    check1("ovr_acked", rx_valid, 1'b0);
    check8("ovr_data_kept", rx_data, 8'hA3);

    // 0x81 with a low stop bit, then a held break.
    send_frame(8'h81, 1'b0);
    repeat (100) @(negedge clk);
    check1("brk_ferr", frame_err, 1'b1);
    check1("brk_valid", rx_valid, 1'b0);
    check1("brk_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check1("brk_idle", busy, 1'b0);
    repeat (200) @(negedge clk);
    check1("brk_no_frame", rx_valid, 1'b0);
    check8("brk_data_kept", rx_data, 8'hA3);
    pulse_clr();
    check1("brk_ferr_clr", frame_err, 1'b0);

    // 4-cycle glitch: START sample sees the line high again.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    check1("glitch_busy", busy, 1'b1);
    repeat (20) @(negedge clk);
    check1("glitch_idle", busy, 1'b0);
    check1("glitch_valid", rx_valid, 1'b0);
    check1("glitch_ferr", frame_err, 1'b0);

    // 0x7E pending; ack coincides with the 0x12 commit edge.
    send_frame(8'h7E, 1'b1);
    check8("pend_data", rx_data, 8'h7E);
    fork
      send_frame(8'h12, 1'b1);
      begin
        repeat (154) @(posedge clk);
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end
    join
    check8("ackc_data", rx_data, 8'h12);
    check1("ackc_valid", rx_valid, 1'b1);
    check1("ackc_ovr", overrun, 1'b0);

    // Reset in the middle of DATA for 0xFF, then receive 0x42.
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        check1("mid_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check8("rst_data", rx_data, 8'h00);
        check1("rst_valid", rx_valid, 1'b0);
        check1("rst_ovr", overrun, 1'b0);
        check1("rst_ferr", frame_err, 1'b0);
        check1("rst_busy", busy, 1'b0);
        reset = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check1("post_rst_valid", rx_valid, 1'b0);
    send_frame(8'h42, 1'b1);
    check8("b42_data", rx_data, 8'h42);
    check1("b42_valid", rx_valid, 1'b1);
    check1("b42_ferr", frame_err, 1'b0);
    check1("b42_ovr", overrun, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
